imem_loader: RTL and testbench
==============================

Name: imem_loader

Overview:
- Boot-time program loader: receives a byte stream over a valid/ready handshake and assembles little-endian 32-bit instruction words.
- Writes the assembled words sequentially into the write port of the instruction memory.
- Holds the core in stall while loading, so instruction memory can be filled at run time rather than from a host file.
- Sits between the external byte source (UART receiver / testbench driver) and the instruction memory.

Parameters:
DEPTH, 1000, number of 32-bit words in instruction memory; maximum legal program length
BASE_ADDR, 0, word index written for the first instruction
LEN_W, 16, width of the length header (word count)

Ports:
SYS_clk  input  1  system clock, all state on rising edge
SYS_reset  input  1  asynchronous, active-high reset
load_start  input  1  one-cycle pulse: begin a new load (honoured only in IDLE, DONE, ERR)
in_valid  input  1  byte source has a byte on in_data
in_data  input  8  stream byte
in_ready  output  1  loader accepts a byte this cycle; transfer = in_valid & in_ready
wr_en  output  1  instruction-memory write strobe, one cycle per word
wr_addr  output  32  word index to write (BASE_ADDR + word_idx)
wr_data  output  32  assembled instruction word
cpu_stall  output  1  high while a load is in progress (HDR0..WRITE)
load_done  output  1  level, high in DONE
load_error  output  1  level, high in ERR
words_loaded  output  LEN_W  count of words written in current/last load

Behaviour:
- Reset (async, any state): state=IDLE. All outputs 0; internal len, word_idx, byte_cnt and shift register cleared. Reset during a word discards the partial word; no write is issued.
- Stream format: byte 0 = len[7:0], byte 1 = len[15:8], then len*4 data bytes. Within each word, the first byte is [7:0] and the fourth is [31:24].
- IDLE: in_ready=0, cpu_stall=0. On load_start -> HDR0.
- HDR0: in_ready=1, cpu_stall=1. On transfer, len[7:0]<=in_data -> HDR1.
- HDR1: in_ready=1. On transfer, len[15:8]<=in_data, then:
  - if full len==0 -> DONE;
  - if len>DEPTH-BASE_ADDR -> ERR;
  - else -> DATA with word_idx=0, byte_cnt=0.
- DATA: in_ready=1. Each transfer shifts the byte into lane byte_cnt and increments byte_cnt (2-bit, wraps). On the transfer with byte_cnt==3 -> WRITE. Without in_valid, the state holds indefinitely.
- WRITE: in_ready=0, wr_en=1, wr_addr=BASE_ADDR+word_idx, wr_data=assembled word.
  - word_idx increments; words_loaded=word_idx+1.
  - If word_idx+1==len -> DONE, else -> DATA.
- Latency: wr_en is asserted exactly one cycle after the fourth byte's transfer. Minimum 5 cycles per word.
- DONE: load_done=1, cpu_stall=0. Holds until load_start -> HDR0, which clears word_idx, words_loaded and load_done.
- ERR: load_error=1, cpu_stall=0, no writes. load_start -> HDR0 clears the error.
- load_start in HDR0..WRITE is ignored.
- wr_addr/wr_data hold their last values when wr_en=0. Only wr_en qualifies them.
- Arithmetic: the len comparison is unsigned on LEN_W bits; wr_addr is zero-extended to 32.

Decomposition:
- Shared package: state encoding (IDLE, HDR0, HDR1, DATA, WRITE, DONE, ERR), header byte count constant (2), bytes-per-word constant (4).
- One natural sub-module, imem_word_packer: byte_cnt plus the 32-bit little-endian shift/lane register. Ports: clk, reset, clear, byte_valid, byte_in, word_out, word_complete.
- FSM, length check and address counter stay in the top module.

Test Plan:
- Single word: start, stream 01 00 13 00 50 00 with in_valid always high -> one wr_en, addr 0, data 0x00500013, one cycle after last byte; load_done=1, words_loaded=1.
- Backpressure and gaps: len=3 with random in_valid gaps -> exactly 3 writes at addrs 0,1,2 with correct data; in_ready low in WRITE cycles; cpu_stall high from HDR0 until DONE.
- Zero length: stream 00 00 -> DONE immediately, no wr_en, words_loaded=0.
- Oversize: stream E9 03 (1001) with DEPTH=1000 -> ERR, load_error=1, no wr_en, further bytes not accepted (in_ready=0).
- Reset mid-operation: assert SYS_reset after 2 bytes of word 1 -> all outputs 0 asynchronously, no write. Later start + len=1 stream writes addr 0 correctly.
- Restart and ignored start: pulse load_start in DATA (ignored, sequence unaffected). After DONE, start a second load of len=2 -> writes again from addr 0, words_loaded=2.

Source files
------------

// File: rtl/imem_loader_pkg.sv
// Shared definitions for the boot-time instruction-memory loader.
//   state_t         : loader FSM states
//   HDR_BYTES       : bytes in the length header
//   BYTES_PER_WORD  : bytes per little-endian instruction word
package imem_loader_pkg;

  localparam int unsigned BYTE_W         = 8;
  localparam int unsigned WORD_W         = 32;
  localparam int unsigned HDR_BYTES      = 2;
  localparam int unsigned BYTES_PER_WORD = 4;
  localparam int unsigned LANE_W         = $clog2(BYTES_PER_WORD);
  localparam int unsigned HDR_LEN_W      = HDR_BYTES * BYTE_W;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_HDR0  = 3'd1,
    ST_HDR1  = 3'd2,
    ST_DATA  = 3'd3,
    ST_WRITE = 3'd4,
    ST_DONE  = 3'd5,
    ST_ERR   = 3'd6
  } state_t;

endpackage

// File: rtl/imem_word_packer.sv
// Assembles a little-endian 32-bit word from a byte stream.
//   clk, reset     : clock, async active-high reset
//   clear          : synchronous clear of lane counter and word register
//   byte_valid     : byte_in is consumed this cycle
//   byte_in        : stream byte
//   word_out       : word register with the current byte merged into its lane
//   word_complete  : combinational, byte_valid on the last lane of a word
module imem_word_packer
  import imem_loader_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              byte_valid,
  input  logic [BYTE_W-1:0] byte_in,
  output logic [WORD_W-1:0] word_out,
  output logic              word_complete
);

  logic [LANE_W-1:0] byte_cnt;
  logic [WORD_W-1:0] word_q;

  // Lane counter and byte lanes; the counter wraps after the last lane.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      byte_cnt <= '0;
      word_q   <= '0;
    end else if (clear) begin
      byte_cnt <= '0;
      word_q   <= '0;
    end else if (byte_valid) begin
      for (int i = 0; i < BYTES_PER_WORD; i++) begin
        if (byte_cnt == LANE_W'(i)) word_q[i*BYTE_W +: BYTE_W] <= byte_in;
      end
      byte_cnt <= byte_cnt + LANE_W'(1);
    end
  end

  // Merge the in-flight byte so the consumer can capture the full word on
  // the same edge that accepts the last byte.
  always_comb begin
    word_out = word_q;
    for (int i = 0; i < BYTES_PER_WORD; i++) begin
      if (byte_cnt == LANE_W'(i)) word_out[i*BYTE_W +: BYTE_W] = byte_in;
    end
  end

  assign word_complete = byte_valid && (byte_cnt == LANE_W'(BYTES_PER_WORD - 1));

endmodule

// File: rtl/imem_loader.sv
// Boot-time program loader: takes a length-prefixed byte stream and writes
// the assembled words sequentially into instruction memory, stalling the core
// while the load runs.
//   SYS_clk, SYS_reset      : clock, async active-high reset
//   load_start              : begin a load (honoured in IDLE, DONE, ERR)
//   in_valid/in_data/in_ready : byte stream handshake
//   wr_en/wr_addr/wr_data   : instruction-memory write port
//   cpu_stall               : load in progress
//   load_done/load_error    : status levels
//   words_loaded            : words written in the current/last load
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int unsigned DEPTH     = 1000,
  parameter int unsigned BASE_ADDR = 0,
  parameter int unsigned LEN_W     = 16
) (
  input  logic              SYS_clk,
  input  logic              SYS_reset,
  input  logic              load_start,
  input  logic              in_valid,
  input  logic [BYTE_W-1:0] in_data,
  output logic              in_ready,
  output logic              wr_en,
  output logic [WORD_W-1:0] wr_addr,
  output logic [WORD_W-1:0] wr_data,
  output logic              cpu_stall,
  output logic              load_done,
  output logic              load_error,
  output logic [LEN_W-1:0]  words_loaded
);

  localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(DEPTH - BASE_ADDR);

  state_t               state, state_next;
  logic [BYTE_W-1:0]    len_lo;
  logic [LEN_W-1:0]     len_q;
  logic [LEN_W-1:0]     word_idx;
  logic [HDR_LEN_W-1:0] hdr_len;
  logic [LEN_W-1:0]     full_len;
  logic                 xfer;
  logic                 start_ok;
  logic                 pack_valid;
  logic                 pack_clear;
  logic                 word_complete;
  logic [WORD_W-1:0]    packed_word;

  assign xfer       = in_valid & in_ready;
  assign hdr_len    = {in_data, len_lo};
  assign full_len   = LEN_W'(hdr_len);
  assign pack_valid = xfer && (state == ST_DATA);

  imem_word_packer u_packer (
    .clk           (SYS_clk),
    .reset         (SYS_reset),
    .clear         (pack_clear),
    .byte_valid    (pack_valid),
    .byte_in       (in_data),
    .word_out      (packed_word),
    .word_complete (word_complete)
  );

  // State register.
  always_ff @(posedge SYS_clk or posedge SYS_reset) begin
    if (SYS_reset) state <= ST_IDLE;
    else           state <= state_next;
  end

  // Next-state logic and per-cycle controls.
  always_comb begin
    state_next = state;
    start_ok   = 1'b0;
    pack_clear = 1'b0;
    case (state)
      ST_IDLE, ST_DONE, ST_ERR: begin
        if (load_start) begin
          state_next = ST_HDR0;
          start_ok   = 1'b1;
        end
      end
      ST_HDR0: begin
        if (xfer) state_next = ST_HDR1;
      end
      ST_HDR1: begin
        if (xfer) begin
          pack_clear = 1'b1;
          if (full_len == '0)          state_next = ST_DONE;
          else if (full_len > MAX_LEN) state_next = ST_ERR;
          else                         state_next = ST_DATA;
        end
      end
      ST_DATA: begin
        if (word_complete) state_next = ST_WRITE;
      end
      ST_WRITE: begin
        // word_idx was advanced on entry, so it now counts words written.
        state_next = (word_idx == len_q) ? ST_DONE : ST_DATA;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Length header, word index and write-port payload.
  always_ff @(posedge SYS_clk or posedge SYS_reset) begin
    if (SYS_reset) begin
      len_lo       <= '0;
      len_q        <= '0;
      word_idx     <= '0;
      words_loaded <= '0;
      wr_addr      <= '0;
      wr_data      <= '0;
    end else begin
      if (start_ok) begin
        len_q        <= '0;
        word_idx     <= '0;
        words_loaded <= '0;
      end
      if ((state == ST_HDR0) && xfer) len_lo <= in_data;
      if ((state == ST_HDR1) && xfer) begin
        len_q    <= full_len;
        word_idx <= '0;
      end
      if ((state == ST_DATA) && word_complete) begin
        wr_addr      <= WORD_W'(BASE_ADDR) + WORD_W'(word_idx);
        wr_data      <= packed_word;
        word_idx     <= word_idx + LEN_W'(1);
        words_loaded <= word_idx + LEN_W'(1);
      end
    end
  end

  // Status and handshake outputs, registered from the upcoming state.
  always_ff @(posedge SYS_clk or posedge SYS_reset) begin
    if (SYS_reset) begin
      in_ready   <= 1'b0;
      wr_en      <= 1'b0;
      cpu_stall  <= 1'b0;
      load_done  <= 1'b0;
      load_error <= 1'b0;
    end else begin
      in_ready   <= state_next inside {ST_HDR0, ST_HDR1, ST_DATA};
      wr_en      <= (state_next == ST_WRITE);
      cpu_stall  <= state_next inside {ST_HDR0, ST_HDR1, ST_DATA, ST_WRITE};
      load_done  <= (state_next == ST_DONE);
      load_error <= (state_next == ST_ERR);
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: a transaction-level model of the load
// protocol predicts every output each cycle; directed and randomized loads.
module tb_imem_loader;

  localparam int unsigned DEPTH     = 1000;
  localparam int unsigned BASE_ADDR = 0;
  localparam int unsigned LEN_W     = 16;

  logic             SYS_clk    = 1'b0;
  logic             SYS_reset  = 1'b0;
  logic             load_start = 1'b0;
  logic             in_valid   = 1'b0;
  logic [7:0]       in_data    = 8'h00;
  logic             in_ready;
  logic             wr_en;
  logic [31:0]      wr_addr;
  logic [31:0]      wr_data;
  logic             cpu_stall;
  logic             load_done;
  logic             load_error;
  logic [LEN_W-1:0] words_loaded;

  imem_loader #(.DEPTH(DEPTH), .BASE_ADDR(BASE_ADDR), .LEN_W(LEN_W)) dut (
    .SYS_clk      (SYS_clk),
    .SYS_reset    (SYS_reset),
    .load_start   (load_start),
    .in_valid     (in_valid),
    .in_data      (in_data),
    .in_ready     (in_ready),
    .wr_en        (wr_en),
    .wr_addr      (wr_addr),
    .wr_data      (wr_data),
    .cpu_stall    (cpu_stall),
    .load_done    (load_done),
    .load_error   (load_error),
    .words_loaded (words_loaded)
  );

  always #5 SYS_clk = ~SYS_clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;
  always @(posedge SYS_clk) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Protocol model: a load is "active" from start until the last word is
  // written; header bytes build the length, data bytes queue up until four
  // form a word, and the cycle after the fourth byte is the write cycle.
  bit          m_active, m_write, m_done, m_err;
  int          m_hdr, m_len, m_count;
  logic [7:0]  m_bytes[$];
  logic [31:0] m_addr, m_data;

  always @(posedge SYS_clk or posedge SYS_reset) begin
    if (SYS_reset) begin
      m_active = 0; m_write = 0; m_done = 0; m_err = 0;
      m_hdr = 0; m_len = 0; m_count = 0; m_addr = 0; m_data = 0;
      m_bytes.delete();
    end else if (m_write) begin
      m_write = 0;
      if (m_count == m_len) begin m_active = 0; m_done = 1; end
    end else if (!m_active) begin
      if (load_start) begin
        m_active = 1; m_done = 0; m_err = 0;
        m_hdr = 0; m_len = 0; m_count = 0;
        m_bytes.delete();
      end
    end else if (in_valid) begin
      if (m_hdr == 0) begin
        m_len = int'(in_data);
        m_hdr = 1;
      end else if (m_hdr == 1) begin
        m_len = m_len + int'(in_data) * 256;
        m_hdr = 2;
        if (m_len == 0)                          begin m_active = 0; m_done = 1; end
        else if (m_len > int'(DEPTH - BASE_ADDR)) begin m_active = 0; m_err  = 1; end
      end else begin
        m_bytes.push_back(in_data);
        if (m_bytes.size() == 4) begin
          m_write = 1;
          m_addr  = 32'(BASE_ADDR) + 32'(m_count);
          m_data  = {m_bytes[3], m_bytes[2], m_bytes[1], m_bytes[0]};
          m_count++;
          m_bytes.delete();
        end
      end
    end
  end

  // Per-cycle compare against the model, plus a log of observed writes.
  logic [31:0] wr_addr_log[$];
  logic [31:0] wr_data_log[$];
  int          wr_cyc_log[$];

  always @(negedge SYS_clk) begin
    check("in_ready",     32'(in_ready),     32'(m_active && !m_write));
    check("cpu_stall",    32'(cpu_stall),    32'(m_active));
    check("wr_en",        32'(wr_en),        32'(m_write));
    check("wr_addr",      wr_addr,           m_addr);
    check("wr_data",      wr_data,           m_data);
    check("load_done",    32'(load_done),    32'(m_done));
    check("load_error",   32'(load_error),   32'(m_err));
    check("words_loaded", 32'(words_loaded), 32'(m_count));
    if (wr_en === 1'b1) begin
      wr_addr_log.push_back(wr_addr);
      wr_data_log.push_back(wr_data);
      wr_cyc_log.push_back(cyc);
    end
  end

  // Stimulus helpers; all are entered and left just after a falling edge.
  logic [7:0]  stim[$];
  logic [31:0] exp_words[$];
  int          last_xfer_cyc;

  task automatic push_hdr(input int unsigned len);
    stim.push_back(8'(len));
    stim.push_back(8'(len >> 8));
  endtask

  task automatic push_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) stim.push_back(w[8*i +: 8]);
    exp_words.push_back(w);
  endtask

  task automatic send_byte(input logic [7:0] b, input int max_gap);
    int  gap;
    bit  acc;
    bit  ok;
    gap = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
    repeat (gap) @(negedge SYS_clk);
    in_valid = 1'b1;
    in_data  = b;
    ok = 0;
    for (int t = 0; t < 200 && !ok; t++) begin
      acc = in_ready;
      @(negedge SYS_clk);
      if (acc) ok = 1;
    end
    if (ok) last_xfer_cyc = cyc;
    else begin
      n_cmp++; n_bad++;
      $display("FAIL byte_accept_timeout: byte %0h not accepted within 200 cycles", b);
    end
    in_valid = 1'b0;
  endtask

  task automatic send_n(input int n, input int max_gap);
    logic [7:0] b;
    for (int i = 0; i < n && stim.size() > 0; i++) begin
      b = stim.pop_front();
      send_byte(b, max_gap);
    end
  endtask

  task automatic pulse_start();
    load_start = 1'b1;
    @(negedge SYS_clk);
    load_start = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge SYS_clk);
  endtask

  task automatic clear_logs();
    wr_addr_log.delete(); wr_data_log.delete(); wr_cyc_log.delete(); exp_words.delete();
  endtask

  // Observed writes must be exactly the queued words at consecutive addresses.
  task automatic expect_writes(input string tag);
    check({tag, "_write_count"}, 32'(wr_addr_log.size()), 32'(exp_words.size()));
    for (int i = 0; i < exp_words.size() && i < wr_addr_log.size(); i++) begin
      check({tag, "_addr"}, wr_addr_log[i], 32'(BASE_ADDR) + 32'(i));
      check({tag, "_data"}, wr_data_log[i], exp_words[i]);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_in_ready"},  32'(in_ready),     32'd0);
    check({tag, "_wr_en"},     32'(wr_en),        32'd0);
    check({tag, "_wr_addr"},   wr_addr,           32'd0);
    check({tag, "_wr_data"},   wr_data,           32'd0);
    check({tag, "_stall"},     32'(cpu_stall),    32'd0);
    check({tag, "_done"},      32'(load_done),    32'd0);
    check({tag, "_error"},     32'(load_error),   32'd0);
    check({tag, "_words"},     32'(words_loaded), 32'd0);
  endtask

  task automatic do_reset_mid();
    #2 SYS_reset = 1'b1;
    in_valid = 1'b0;
    #1 check_all_zero("async_reset");
    @(negedge SYS_clk);
    SYS_reset = 1'b0;
    @(negedge SYS_clk);
  endtask

  initial begin
    int n;
    #1 SYS_reset = 1'b1;
    #1 check_all_zero("por");
    @(negedge SYS_clk);
    @(negedge SYS_clk);
    SYS_reset = 1'b0;
    idle(2);

    // Single word, no gaps.
    clear_logs();
    pulse_start();
    push_hdr(1); push_word(32'h0050_0013);
    send_n(6, 0);
    idle(3);
    expect_writes("single");
    check("single_lit_model", m_data, 32'h0050_0013);
    if (wr_data_log.size() > 0) check("single_lit_data", wr_data_log[0], 32'h0050_0013);
    // The write cycle is the one that begins at the edge accepting byte 4.
    if (wr_cyc_log.size() > 0) check("single_latency", 32'(wr_cyc_log[0]), 32'(last_xfer_cyc));
    check("single_done",  32'(load_done),    32'd1);
    check("single_words", 32'(words_loaded), 32'd1);

    // Three words with random valid gaps.
    clear_logs();
    pulse_start();
    push_hdr(3);
    for (int i = 0; i < 3; i++) push_word($urandom);
    send_n(14, 3);
    idle(4);
    expect_writes("gaps");
    check("gaps_words", 32'(words_loaded), 32'd3);

    // Zero-length program.
    clear_logs();
    pulse_start();
    push_hdr(0);
    send_n(2, 0);
    idle(3);
    expect_writes("zero");
    check("zero_done",  32'(load_done),    32'd1);
    check("zero_words", 32'(words_loaded), 32'd0);

    // Oversize length, then bytes offered while in error.
    clear_logs();
    pulse_start();
    push_hdr(1001);
    send_n(2, 0);
    idle(2);
    in_valid = 1'b1; in_data = 8'hA5;
    idle(5);
    in_valid = 1'b0;
    expect_writes("oversize");
    check("oversize_error", 32'(load_error), 32'd1);

    // Largest legal length is accepted; reset lands inside the third word.
    clear_logs();
    pulse_start();
    push_hdr(DEPTH);
    push_word($urandom); push_word($urandom);
    send_n(10, 1);
    idle(2);
    stim.push_back(8'h11); stim.push_back(8'h22);
    send_n(2, 0);
    check("max_len_no_error", 32'(load_error), 32'd0);
    do_reset_mid();
    expect_writes("max_len");

    // Fresh load after reset.
    clear_logs();
    pulse_start();
    push_hdr(1); push_word(32'hDEAD_BEEF);
    send_n(6, 1);
    idle(3);
    expect_writes("after_reset");
    if (wr_data_log.size() > 0) check("after_reset_lit", wr_data_log[0], 32'hDEAD_BEEF);

    // Start pulse during DATA is ignored; then a second load restarts at 0.
    clear_logs();
    pulse_start();
    push_hdr(2); push_word($urandom); push_word($urandom);
    send_n(4, 0);
    pulse_start();
    send_n(6, 1);
    idle(3);
    expect_writes("ignored_start");
    clear_logs();
    pulse_start();
    push_hdr(2); push_word($urandom); push_word($urandom);
    send_n(10, 2);
    idle(3);
    expect_writes("restart");
    check("restart_words", 32'(words_loaded), 32'd2);

    // Randomized loads.
    for (int k = 0; k < 4; k++) begin
      clear_logs();
      n = int'($urandom_range(5, 1));
      pulse_start();
      push_hdr(n);
      for (int i = 0; i < n; i++) push_word($urandom);
      send_n(2 + 4 * n, 2);
      idle(3);
      expect_writes("random");
      check("random_done", 32'(load_done), 32'd1);
    end

    idle(2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    n_bad++;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $fatal(1, "watchdog");
  end

endmodule
